// File: rtl/prime_ctrl.sv
// -----------------------------------------------------------------------------
// prime_ctrl
//
// Sequencing controller that tests an unsigned 15-bit value for primality by
// trial division on an external combinational 16-bit ALU. The controller owns
// the operand registers (N, D, R), drives the ALU control and operand ports
// every cycle, and consumes the ALU result and flags in the same cycle.
//
// Algorithm: D starts at 2. CHK compares N against D. TEST subtracts D from R
// repeatedly until R hits zero (composite) or drops below D (try the next
// divisor). NEXT increments D.
//
// Ports
//   clk     in   1   system clock, rising edge
//   rst     in   1   asynchronous active-high reset
//   start   in   1   request pulse, sampled only in IDLE
//   n       in  16   value to test, latched on an accepted start
//   busy    out  1   high from the cycle after acceptance through DONE
//   done    out  1   one-cycle pulse, result valid
//   prime   out  1   result, held until the next accepted start
//   err     out  1   n[15] was set (out of range), held like prime
//   alu_x   out 16   ALU operand x
//   alu_y   out 16   ALU operand y
//   alu_zc  out  2   ALU result select (0=x, 1=y+1, 2=x-y, 3=const 2)
//   alu_sc  out  2   ALU compare select (0: x==2, 1: x==0, 2/3: x==y)
//   alu_z   in  16   ALU result
//   alu_s   in   2   ALU status ([0]=sign of x-y, [1]=equality)
//   cycles  out 16   (only with PRIME_CTRL_CYCCNT_EN) edges from acceptance
//                    to done, saturating at 16'hFFFF
//
// Build option: define PRIME_CTRL_CYCCNT_EN to add the cycles output and its
// counter. Without it, there is no cycles port and no counter logic.
// -----------------------------------------------------------------------------
module prime_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] n,
    output logic        busy,
    output logic        done,
    output logic        prime,
    output logic        err,
`ifdef PRIME_CTRL_CYCCNT_EN
    output logic [15:0] cycles,
`endif
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [1:0]  alu_zc,
    output logic [1:0]  alu_sc,
    input  logic [15:0] alu_z,
    input  logic [1:0]  alu_s
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD2 = 3'd1,
        S_CHK   = 3'd2,
        S_TEST  = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] ZC_X     = 2'd0;
    localparam logic [1:0] ZC_YINC  = 2'd1;
    localparam logic [1:0] ZC_SUB   = 2'd2;
    localparam logic [1:0] ZC_TWO   = 2'd3;
    localparam logic [1:0] SC_EQ2   = 2'd0;
    localparam logic [1:0] SC_ZERO  = 2'd1;
    localparam logic [1:0] SC_EQXY  = 2'd2;

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] d_q, d_d;
    logic [15:0] r_q, r_d;
    logic        prime_q, prime_d;
    logic        err_q, err_d;

    // Sign of x-y is an exact less-than only because N (and hence R, D) stays
    // below 2^15; out-of-range requests never reach CHK.
    logic        lt_flag;
    logic        eq_flag;
    assign lt_flag = alu_s[0];
    assign eq_flag = alu_s[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            prime_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            r_q     <= r_d;
            prime_q <= prime_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        r_d     = r_q;
        prime_d = prime_q;
        err_d   = err_q;
        // Idle/DONE drive: pass-through of N with the x==2 compare.
        alu_x   = n_q;
        alu_y   = d_q;
        alu_zc  = ZC_X;
        alu_sc  = SC_EQ2;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = n;
                    prime_d = 1'b0;
                    if (n[15]) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_LOAD2;
                    end
                end
            end

            S_LOAD2: begin
                alu_zc  = ZC_TWO;
                d_d     = alu_z;
                state_d = S_CHK;
            end

            S_CHK: begin
                alu_zc = ZC_SUB;
                alu_sc = SC_EQXY;
                if (eq_flag) begin
                    // No divisor below N divided it.
                    prime_d = 1'b1;
                    state_d = S_DONE;
                end else if (lt_flag) begin
                    // Only reachable for N = 0 or 1.
                    prime_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    r_d     = alu_z;
                    state_d = S_TEST;
                end
            end

            S_TEST: begin
                alu_x  = r_q;
                alu_zc = ZC_SUB;
                alu_sc = SC_ZERO;
                if (eq_flag) begin
                    prime_d = 1'b0;
                    state_d = S_DONE;
                end else if (lt_flag) begin
                    state_d = S_NEXT;
                end else begin
                    r_d = alu_z;
                end
            end

            S_NEXT: begin
                alu_zc  = ZC_YINC;
                d_d     = alu_z;
                state_d = S_CHK;
            end

            S_DONE: begin
                // start is deliberately ignored here; earliest re-accept is
                // the following IDLE cycle.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign prime = prime_q;
    assign err   = err_q;

`ifdef PRIME_CTRL_CYCCNT_EN
    logic [15:0] cyc_q, cyc_d;

    // Acceptance edge counts as 1; every edge leaving a working state counts,
    // including the one that enters DONE. DONE/IDLE hold the value.
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                cyc_d = 16'd1;
            end
        end else if (state_q != S_DONE) begin
            if (cyc_q != 16'hFFFF) begin
                cyc_d = cyc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_prime_ctrl.sv
module tb_prime_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] n;
    logic        busy;
    logic        done;
    logic        prime;
    logic        err;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [1:0]  alu_zc;
    logic [1:0]  alu_sc;
    logic [15:0] alu_z;
    logic [1:0]  alu_s;
`ifdef PRIME_CTRL_CYCCNT_EN
    logic [15:0] cycles;
`endif

    always #5 clk = ~clk;

    prime_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .prime  (prime),
        .err    (err),
`ifdef PRIME_CTRL_CYCCNT_EN
        .cycles (cycles),
`endif
        .alu_x  (alu_x),
        .alu_y  (alu_y),
        .alu_zc (alu_zc),
        .alu_sc (alu_sc),
        .alu_z  (alu_z),
        .alu_s  (alu_s)
    );

    // Combinational ALU attached to the controller.
    logic [15:0] diff;
    always_comb begin
        diff = alu_x - alu_y;
        case (alu_zc)
            2'd0:    alu_z = alu_x;
            2'd1:    alu_z = alu_y + 16'd1;
            2'd2:    alu_z = diff;
            default: alu_z = 16'd2;
        endcase
        alu_s[0] = diff[15];
        case (alu_sc)
            2'd0:    alu_s[1] = (alu_x == 16'd2);
            2'd1:    alu_s[1] = (alu_x == 16'd0);
            default: alu_s[1] = (alu_x == alu_y);
        endcase
    end

    // Edge counter: at a falling edge it equals the number of rising edges so far.
    int unsigned cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    typedef struct {
        bit          prime;
        bit          err;
        int unsigned lat;
        int unsigned cyc;
        logic [15:0] nval;
    } exp_t;

    exp_t        expq[$];
    int unsigned accq[$];
    int          checks = 0;
    int          failures = 0;
    int          ndone = 0;
    bit          last_prime = 0;
    bit          last_err = 0;
    logic [15:0] last_n = '0;
    bit          have_last = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain trial division. Each divisor costs one compare, then
    // floor(N/d) subtraction steps, then one increment if it did not divide.
    function automatic exp_t model(input logic [15:0] v);
        exp_t        e;
        int unsigned nv;
        e.nval  = v;
        e.prime = 0;
        e.err   = 0;
        if (v[15]) begin
            e.err = 1;
            e.lat = 1;
        end else begin
            nv    = int'(v);
            e.lat = 2;
            for (int unsigned d = 2; d <= 32768; d++) begin
                e.lat++;
                if (nv == d) begin e.prime = 1; break; end
                if (nv < d)  begin e.prime = 0; break; end
                e.lat += nv / d;
                if (nv % d == 0) begin e.prime = 0; break; end
                e.lat++;
            end
        end
        e.cyc = (e.lat > 65535) ? 65535 : e.lat;
        return e;
    endfunction

    // Monitor: records acceptances, scores every done, checks held outputs.
    initial begin
        bit   busy_prev;
        exp_t e;
        int unsigned acc;
        busy_prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 0;
                continue;
            end
            if (busy && !busy_prev) accq.push_back(cnt);
            if (done) begin
                ndone++;
                if (expq.size() == 0 || accq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e   = expq.pop_front();
                    acc = accq.pop_front();
                    check($sformatf("prime_n%0d", e.nval), prime, e.prime);
                    check($sformatf("err_n%0d", e.nval), err, e.err);
                    check($sformatf("latency_n%0d", e.nval), cnt - acc + 1, e.lat);
`ifdef PRIME_CTRL_CYCCNT_EN
                    check($sformatf("cycles_n%0d", e.nval), cycles, e.cyc);
`endif
                    last_prime = e.prime;
                    last_err   = e.err;
                    last_n     = e.nval;
                    have_last  = 1;
                end
            end else if (!busy && have_last) begin
                check("hold_prime", prime, last_prime);
                check("hold_err", err, last_err);
                check("idle_alu_x", alu_x, last_n);
                check("idle_alu_zc", alu_zc, 0);
                check("idle_alu_sc", alu_sc, 0);
            end
            busy_prev = busy;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_prime"}, prime, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_alu_x"}, alu_x, 0);
        check({tag, "_alu_y"}, alu_y, 0);
        check({tag, "_alu_zc"}, alu_zc, 0);
        check({tag, "_alu_sc"}, alu_sc, 0);
`ifdef PRIME_CTRL_CYCCNT_EN
        check({tag, "_cycles"}, cycles, 0);
`endif
    endtask

    task automatic clear_sb();
        expq.delete();
        accq.delete();
        last_prime = 0;
        last_err   = 0;
        last_n     = '0;
        have_last  = 1;
    endtask

    // Issue one request from an idle controller; does not wait for completion.
    task automatic issue(input logic [15:0] v);
        @(negedge clk);
        start = 1'b1;
        n     = v;
        expq.push_back(model(v));
        @(posedge clk);
        #1;
        check("busy_after_accept", busy, 1);
        start = 1'b0;
        n     = 16'($urandom);
    endtask

    // Bounded wait until the controller is idle and every expectation is scored.
    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (!busy && expq.size() == 0) return;
        end
        check("timeout_wait_idle", 0, 1);
        rst = 1'b1;
        #1;
        clear_sb();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input logic [15:0] v, input int gap);
        issue(v);
        wait_idle(600000);
        repeat (gap) @(posedge clk);
    endtask

    initial begin
        logic [15:0] dir[10];
        logic [15:0] v;
        int          base;
        dir = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd97, 16'd91,
                16'h8000, 16'd5, 16'd32749};

        rst   = 1'b1;
        start = 1'b0;
        n     = '0;
        #1;
        check_all_zero("reset");
        clear_sb();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed values, including out-of-range and the largest 15-bit prime.
        foreach (dir[i]) run(dir[i], i % 2);

        // Reset while a run of 97 is in its subtraction loop.
        issue(16'd97);
        repeat (5) @(posedge clk);
        #2;
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_all_zero("midrun_reset");
        clear_sb();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        run(16'd97, 1);

        // start held high: one done per run, re-accepted only after DONE.
        base = ndone;
        @(negedge clk);
        start = 1'b1;
        n     = 16'd6;
        for (int k = 0; k < 3; k++) expq.push_back(model(16'd6));
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (ndone >= base + 3) break;
        end
        start = 1'b0;
        check("held_start_runs", ndone - base, 3);
        wait_idle(200);
        repeat (5) @(posedge clk);
        check("held_start_no_extra", ndone - base, 3);

        // Randomized requests with occasional out-of-range values.
        for (int i = 0; i < 24; i++) begin
            v = 16'($urandom_range(0, 600));
            if ($urandom_range(0, 7) == 0) v[15] = 1'b1;
            run(v, $urandom_range(0, 3));
        end

        check("scoreboard_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
